// File: rtl/nco_phase_freq_meter.sv
// nco_phase_freq_meter
// Receive-side phase/frequency meter for the NCO. Each accepted sin/cos pair
// is converted to a phase with a sequential vectoring CORDIC (one
// micro-rotation per enabled clock). Successive phase differences are
// averaged over 2^LOG2_AVG samples to estimate the generating phase increment.
module nco_phase_freq_meter #(
    parameter int DW       = 14,
    parameter int PW       = 32,
    parameter int ITER     = 16,
    parameter int LOG2_AVG = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] sin_i,
    input  logic signed [DW-1:0] cos_i,
    output logic [PW-1:0]        phase_o,
    output logic                 phase_valid,
    output logic [PW-1:0]        phi_inc_o,
    output logic                 out_valid
);

    // Datapath widths: 4 guard bits cover the CORDIC gain on |v| <= sqrt(2)*2^(DW-1)
    localparam int XW = DW + 4;
    localparam int AW = PW + LOG2_AVG;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

    // The arctangent table is held at 32-bit resolution and rounded down to PW
    localparam int          ATAN_SH   = (PW < 32) ? (32 - PW) : 0;
    localparam int          ATAN_RSH  = (ATAN_SH > 0) ? (ATAN_SH - 1) : 0;
    localparam logic [32:0] ATAN_RND  = (ATAN_SH > 0) ? (33'd1 << ATAN_RSH) : 33'd0;
    localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ITER = 2'd2,
        ST_POST = 2'd3
    } state_t;

    // round(atan(2^-i) / (2*pi) * 2^32), rescaled to PW bits
    function automatic logic [PW-1:0] atan_f(input logic [4:0] idx);
        logic [31:0] a32;
        logic [32:0] a33;
        case (idx)
            5'd0:    a32 = 32'h2000_0000;
            5'd1:    a32 = 32'h12E4_051E;
            5'd2:    a32 = 32'h09FB_385B;
            5'd3:    a32 = 32'h0511_11D4;
            5'd4:    a32 = 32'h028B_0D43;
            5'd5:    a32 = 32'h0145_D7E1;
            5'd6:    a32 = 32'h00A2_F61E;
            5'd7:    a32 = 32'h0051_7C55;
            5'd8:    a32 = 32'h0028_BE53;
            5'd9:    a32 = 32'h0014_5F2F;
            5'd10:   a32 = 32'h000A_2F98;
            5'd11:   a32 = 32'h0005_17CC;
            5'd12:   a32 = 32'h0002_8BE6;
            5'd13:   a32 = 32'h0001_45F3;
            5'd14:   a32 = 32'h0000_A2FA;
            5'd15:   a32 = 32'h0000_517D;
            5'd16:   a32 = 32'h0000_28BE;
            5'd17:   a32 = 32'h0000_145F;
            5'd18:   a32 = 32'h0000_0A30;
            5'd19:   a32 = 32'h0000_0518;
            5'd20:   a32 = 32'h0000_028C;
            5'd21:   a32 = 32'h0000_0146;
            5'd22:   a32 = 32'h0000_00A3;
            5'd23:   a32 = 32'h0000_0051;
            5'd24:   a32 = 32'h0000_0029;
            5'd25:   a32 = 32'h0000_0014;
            5'd26:   a32 = 32'h0000_000A;
            5'd27:   a32 = 32'h0000_0005;
            5'd28:   a32 = 32'h0000_0003;
            5'd29:   a32 = 32'h0000_0001;
            5'd30:   a32 = 32'h0000_0001;
            default: a32 = 32'h0000_0000;
        endcase
        a33 = {1'b0, a32} + ATAN_RND;
        return PW'(a33 >> ATAN_SH);
    endfunction

    state_t               state_r;
    logic [IW-1:0]        iter_cnt_r;
    logic signed [XW-1:0] x_r;
    logic signed [XW-1:0] y_r;
    logic [PW-1:0]        z_r;
    logic                 zero_r;
    logic                 have_prev_r;
    logic [PW-1:0]        prev_phase_r;
    logic [AW-1:0]        acc_r;
    logic [LOG2_AVG-1:0]  cnt_r;
    logic                 avg_pend_r;
    logic                 in_ready_r;
    logic [PW-1:0]        phase_r;
    logic                 phase_valid_r;
    logic [PW-1:0]        phi_inc_r;
    logic                 out_valid_r;

    logic [PW-1:0]        atan_s;
    logic signed [XW-1:0] x_sh_s;
    logic signed [XW-1:0] y_sh_s;
    logic signed [XW-1:0] x_step_s;
    logic signed [XW-1:0] y_step_s;
    logic [PW-1:0]        z_step_s;
    logic [PW-1:0]        diff_s;
    logic [AW-1:0]        acc_sum_s;

    // One CORDIC micro-rotation plus the phase-difference accumulation term
    always_comb begin
        atan_s = atan_f(5'(iter_cnt_r));
        x_sh_s = x_r >>> iter_cnt_r;
        y_sh_s = y_r >>> iter_cnt_r;
        if (!y_r[XW-1]) begin
            x_step_s = x_r + y_sh_s;
            y_step_s = y_r - x_sh_s;
            z_step_s = z_r + atan_s;
        end else begin
            x_step_s = x_r - y_sh_s;
            y_step_s = y_r + x_sh_s;
            z_step_s = z_r - atan_s;
        end
        diff_s    = z_r - prev_phase_r;
        acc_sum_s = acc_r + {{LOG2_AVG{diff_s[PW-1]}}, diff_s};
    end

    // Control FSM, CORDIC registers, frequency accumulator and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            iter_cnt_r    <= '0;
            x_r           <= '0;
            y_r           <= '0;
            z_r           <= '0;
            zero_r        <= 1'b0;
            have_prev_r   <= 1'b0;
            prev_phase_r  <= '0;
            acc_r         <= '0;
            cnt_r         <= '0;
            avg_pend_r    <= 1'b0;
            in_ready_r    <= 1'b1;
            phase_r       <= '0;
            phase_valid_r <= 1'b0;
            phi_inc_r     <= '0;
            out_valid_r   <= 1'b0;
        end else if (clken) begin
            phase_valid_r <= 1'b0;
            out_valid_r   <= 1'b0;

            // A completed window is published one cycle after its last phase
            if (avg_pend_r) begin
                phi_inc_r   <= acc_r[AW-1:LOG2_AVG];
                out_valid_r <= 1'b1;
                acc_r       <= '0;
                cnt_r       <= '0;
                avg_pend_r  <= 1'b0;
            end else begin
                avg_pend_r  <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r        <= {{4{cos_i[DW-1]}}, cos_i};
                        y_r        <= {{4{sin_i[DW-1]}}, sin_i};
                        zero_r     <= (cos_i == '0) && (sin_i == '0);
                        in_ready_r <= 1'b0;
                        state_r    <= ST_PRE;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_PRE: begin
                    // Fold the left half-plane onto the right by a half-turn rotation
                    if (x_r[XW-1]) begin
                        x_r <= -x_r;
                        y_r <= -y_r;
                        z_r <= {1'b1, {(PW-1){1'b0}}};
                    end else begin
                        z_r <= '0;
                    end
                    iter_cnt_r <= '0;
                    state_r    <= ST_ITER;
                end
                ST_ITER: begin
                    x_r <= x_step_s;
                    y_r <= y_step_s;
                    z_r <= z_step_s;
                    if (iter_cnt_r == ITER_LAST) begin
                        iter_cnt_r <= '0;
                        state_r    <= ST_POST;
                    end else begin
                        iter_cnt_r <= iter_cnt_r + IW'(1);
                    end
                end
                ST_POST: begin
                    phase_valid_r <= 1'b1;
                    in_ready_r    <= 1'b1;
                    state_r       <= ST_IDLE;
                    if (zero_r) begin
                        // A zero vector has no phase; it must not disturb the estimate
                        phase_r <= '0;
                    end else begin
                        phase_r      <= z_r;
                        prev_phase_r <= z_r;
                        if (!have_prev_r) begin
                            have_prev_r <= 1'b1;
                        end else begin
                            acc_r <= acc_sum_s;
                            cnt_r <= cnt_r + LOG2_AVG'(1);
                            if (cnt_r == '1) begin
                                avg_pend_r <= 1'b1;
                            end else begin
                                avg_pend_r <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign phase_o     = phase_r;
    assign phase_valid = phase_valid_r;
    assign phi_inc_o   = phi_inc_r;
    assign out_valid   = out_valid_r;

endmodule

// File: doc/nco_phase_freq_meter.md
Name: nco_phase_freq_meter

Overview:
- Receive-side counterpart of the NCO: consumes signed sin/cos sample pairs, as produced on the NCO's fsin_o/fcos_o, and recovers the instantaneous phase and the phase increment (frequency word) that generated them.
- Phase is computed with an iterative CORDIC in vectoring mode, one micro-rotation per clock.
- Successive phase differences are averaged over 2^LOG2_AVG samples to give a phi_inc estimate in the same units as the NCO phi_inc_i.
- Used for NCO loop-back self-test and carrier frequency measurement.

Parameters:
- DW, 14: sample width, two's complement.
- PW, 32: phase / phase-increment width; full scale 2^PW = one turn.
- ITER, 16: CORDIC micro-rotations per sample, 8..PW-2.
- LOG2_AVG, 4: log2 of the number of phase differences averaged per estimate.

Ports:
- clk, in, 1: clock, all logic on rising edge.
- reset, in, 1: synchronous, active-high reset.
- clken, in, 1: clock enable; low freezes all state and holds all outputs.
- in_valid, in, 1: sample pair present.
- in_ready, out, 1: block can accept a sample.
- sin_i, in, DW: signed sine (y) sample.
- cos_i, in, DW: signed cosine (x) sample.
- phase_o, out, PW: phase of the last sample, unsigned turns.
- phase_valid, out, 1: one-cycle pulse, phase_o updated.
- phi_inc_o, out, PW: averaged phase increment, two's complement.
- out_valid, out, 1: one-cycle pulse, phi_inc_o updated.

Behaviour:
- Reset values:
  - in_ready = 1; phase_o, phi_inc_o, phase_valid, out_valid = 0.
  - FSM = IDLE; accumulator, counter and first-sample flag cleared.
  - Reset wins over clken.
- clken = 0: no state changes; pulses are not repeated. Every latency figure below is counted in clken-high cycles.
- Accept: on the edge where in_valid & in_ready & clken are all high. in_ready = (state == IDLE). in_valid while busy is ignored, not queued.
- FSM states: IDLE -> PRE -> ITER (ITER cycles) -> POST -> IDLE.
- PRE:
  - Sign-extend x and y to DW+4 bits.
  - If x < 0: negate x and y, set z = 2^(PW-1). Otherwise z = 0.
- ITER step i, for i = 0..ITER-1:
  - If y >= 0: x += y>>>i, y -= x>>>i, z += A[i]. Otherwise the opposite signs.
  - Right shifts are arithmetic; x and y update from their old values.
  - A[i] = round(atan(2^-i) / (2*pi) * 2^PW); for example A[0] = 2^(PW-3).
  - z wraps modulo 2^PW.
- POST:
  - Drive phase_o = z and pulse phase_valid.
  - Latency: accept edge to phase_valid high = ITER+2 cycles.
  - Maximum throughput: one sample per ITER+3 cycles.
- Zero input (sin_i = cos_i = 0):
  - phase_o = 0 and phase_valid still pulses.
  - The sample is excluded from frequency estimation: prev_phase, accumulator and counter are untouched.
- Frequency path, evaluated in POST:
  - First valid (non-zero) sample after reset: store prev_phase, no difference is formed.
  - After that: d = (z - prev_phase) mod 2^PW, read as signed PW bits, so increments above 2^(PW-1) mean negative frequency.
  - Sign-extend d into a PW+LOG2_AVG accumulator, then set prev_phase = z.
- Output:
  - When 2^LOG2_AVG differences have been accumulated, phi_inc_o = acc >>> LOG2_AVG (arithmetic, truncating).
  - out_valid pulses one cycle after the phase_valid of that sample.
  - The accumulator and counter then clear; prev_phase is kept, so windows are contiguous.
- Accuracy: for inputs with magnitude >= 2^(DW-2), |phase_o error| <= 2^(PW-DW+4) LSB.
- Reset mid-operation: the sample in flight is discarded (no phase_valid, no out_valid). The next accepted sample is treated as the first.

Test Plan:
- Reset and idle: hold reset 3 cycles with in_valid = 1. Require in_ready = 1 and all outputs 0, with no phase_valid or out_valid pulse.
- Static quadrants, expected phase_o within +/-2^(PW-DW+4):
  - (cos, sin) = (8191, 0): 0x00000000.
  - (0, 8191): 0x40000000.
  - (-8191, 0): 0x80000000.
  - (0, -8191): 0xC0000000.
  - (5792, 5792): 0x20000000.
  - Each with phase_valid exactly ITER+2 = 18 cycles after accept.
- Loop-back tone: reference NCO model with phi_inc = 0x10000000 and amplitude 8191, feeding 17 samples.
  - Require exactly one out_valid, phi_inc_o = 0x10000000 +/- 2^16.
  - Phase wraps through 0x80000000 and 0x00000000 without error.
- Negative frequency: phi_inc = 0xF0000000, 17 samples -> phi_inc_o = 0xF0000000 +/- 2^16.
- Handshake and clken:
  - in_valid held high: samples accepted every 19 cycles; pulses in between are ignored.
  - clken low for 5 cycles mid-ITER: phase_valid is delayed by exactly 5 cycles, with a bit-identical result.
- Zero and reset cases:
  - A (0, 0) sample inside the tone gives phase_o = 0 and leaves phi_inc_o unchanged.
  - Reset asserted at ITER step 7: no phase_valid is produced.
  - After that reset, 16 more tone samples produce no out_valid; the 17th does.
